// File: rtl/rob_pkg.sv
// rob_pkg: shared uid geometry, pool types and helpers for the R reorder block
package rob_pkg;
  localparam int ROW_W = 4;
  localparam int COL_W = 4;
  localparam int UID_W = ROW_W + COL_W;
  localparam int PTR_W = 5;
  typedef logic [PTR_W-1:0] rm_ptr_t;
  typedef struct packed {
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
    rm_ptr_t     next;
  } rm_entry_t;
  function automatic int uid_width(input int rows, input int cols);
    return $clog2(rows) + $clog2(cols);
  endfunction
endpackage

// File: rtl/r_if.sv
// r_if: AXI-style R channel bundle (id, data, resp, last with valid/ready)
interface r_if #(
  parameter int ID_WIDTH   = 32,
  parameter int DATA_WIDTH = 64,
  parameter int RESP_WIDTH = 2
);
  logic [ID_WIDTH-1:0]   id;
  logic [DATA_WIDTH-1:0] data;
  logic [RESP_WIDTH-1:0] resp;
  logic                  last;
  logic                  valid;
  logic                  ready;
  modport sender(output id, data, resp, last, valid, input ready);
  modport receiver(input id, data, resp, last, valid, output ready);
endinterface

// File: rtl/r_response_memory_free_list.sv
// rm_free_list: slot free map with lowest-index allocation
module rm_free_list #(
  parameter int DEPTH = 32,
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          alloc_en,
  input  logic          free_en,
  input  logic [PW-1:0] free_idx,
  output logic          alloc_valid,
  output logic [PW-1:0] alloc_idx
);
  logic [DEPTH-1:0] free_map;
  assign alloc_valid = |free_map;
  always_comb begin
    alloc_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--)
      if (free_map[i]) alloc_idx = PW'(i);
  end
  // a freed slot only shows up in the map next cycle, so it is never re-allocated in the cycle it frees
  always_ff @(posedge clk or posedge rst)
    if (rst) free_map <= '1;
    else begin
      if (alloc_en) free_map[alloc_idx] <= 1'b0;
      if (free_en) free_map[free_idx] <= 1'b1;
    end
endmodule

// File: rtl/r_response_memory.sv
// r_response_memory: shared-pool store of early R beats, kept as per-uid linked lists
module r_response_memory
  import rob_pkg::*;
#(
  parameter int ID_WIDTH   = 32,
  parameter int DATA_WIDTH = 64,
  parameter int RESP_WIDTH = 2,
  parameter int NUM_ROWS   = 16,
  parameter int NUM_COLS   = 16,
  parameter int DEPTH      = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  r_if.receiver                      r_store,
  input  logic [ID_WIDTH-1:0]        release_uid,
  r_if.sender                        r_release,
  output logic [$clog2(DEPTH+1)-1:0] rm_occupancy,
  output logic                       rm_full,
  output logic                       rm_empty
);
  localparam int UW = uid_width(NUM_ROWS, NUM_COLS);
  localparam int NU = 1 << UW;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [RESP_WIDTH-1:0] resp;
    logic                  last;
    logic [PW-1:0]         next;
  } entry_t;
  entry_t        entry [DEPTH];
  logic [PW-1:0] head [NU];
  logic [PW-1:0] tail [NU];
  logic [CW-1:0] cnt [NU];
  logic [CW-1:0] occ, cnt_after;
  logic [UW-1:0] s_uid, r_uid;
  logic [PW-1:0] slot, hd;
  logic          alloc_valid, store_hs, rel_v, rel_hs, unused_id;
  assign s_uid     = r_store.id[UW-1:0];
  assign r_uid     = release_uid[UW-1:0];
  assign unused_id = ^{r_store.id[ID_WIDTH-1:UW], release_uid[ID_WIDTH-1:UW]};
  assign hd        = head[r_uid];
  assign rel_v     = cnt[r_uid] != '0;
  assign rel_hs    = rel_v && r_release.ready;
  assign store_hs  = r_store.valid && alloc_valid;
  assign cnt_after = cnt[s_uid] - CW'(rel_hs && r_uid == s_uid);
  assign r_store.ready   = alloc_valid;
  assign r_release.valid = rel_v;
  assign r_release.id    = release_uid;
  assign r_release.data  = rel_v ? entry[hd].data : '0;
  assign r_release.resp  = rel_v ? entry[hd].resp : '0;
  assign r_release.last  = rel_v && entry[hd].last;
  assign rm_occupancy    = occ;
  assign rm_full         = occ == CW'(DEPTH);
  assign rm_empty        = occ == '0;
  rm_free_list #(.DEPTH(DEPTH), .PW(PW)) u_fl (
    .clk         (clk),
    .rst         (rst),
    .alloc_en    (store_hs),
    .free_en     (rel_hs),
    .free_idx    (hd),
    .alloc_valid (alloc_valid),
    .alloc_idx   (slot)
  );
  // a store into a uid that a same-cycle release empties starts a fresh list instead of linking
  always_ff @(posedge clk) begin
    if (rel_hs) head[r_uid] <= entry[hd].next;
    if (store_hs) begin
      entry[slot] <= {r_store.data, r_store.resp, r_store.last, PW'(0)};
      if (cnt_after != '0) entry[tail[s_uid]].next <= slot;
      if (cnt_after == '0) head[s_uid] <= slot;
      tail[s_uid] <= slot;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '{default: '0};
      occ <= '0;
    end else begin
      if (rel_hs) cnt[r_uid] <= cnt[r_uid] - CW'(1);
      if (store_hs) cnt[s_uid] <= cnt_after + CW'(1);
      occ <= occ + CW'(store_hs) - CW'(rel_hs);
    end
  a_no_store_full: assert property (@(posedge clk) disable iff (rst) !(store_hs && rm_full));
  a_occ_match: assert property (@(posedge clk) disable iff (rst)
    int'(occ) == DEPTH - $countones(u_fl.free_map));
  a_last_final: assert property (@(posedge clk) disable iff (rst)
    rel_v && r_release.last |-> cnt[r_uid] == CW'(1));
endmodule

// File: tb/tb_r_response_memory.sv
// tb_r_response_memory: directed table-driven and sequence checks of the R beat store
module tb_r_response_memory;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] release_uid;
  logic [2:0]  occ;
  logic        full, empty;
  int          n_vec = 0;
  int          n_bad = 0;
  always #5 clk = ~clk;
  r_if #(.ID_WIDTH(32), .DATA_WIDTH(64), .RESP_WIDTH(2)) st ();
  r_if #(.ID_WIDTH(32), .DATA_WIDTH(64), .RESP_WIDTH(2)) rl ();
  r_response_memory #(.DEPTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .r_store      (st),
    .release_uid  (release_uid),
    .r_release    (rl),
    .rm_occupancy (occ),
    .rm_full      (full),
    .rm_empty     (empty)
  );
  typedef struct {
    logic sv; logic [7:0] suid; logic [63:0] sd; logic [1:0] sr; logic sl;
    logic [7:0] ruid; logic rr;
    logic ev; logic [63:0] ed; logic [1:0] er; logic el; logic [2:0] eo;
  } vec_t;
  vec_t tv [13];
  localparam logic [63:0] DA = 64'hA5A5_0000_0000_000A, DB = 64'hB6B6_0000_0000_000B;
  localparam logic [63:0] DC = 64'hC7C7_0000_0000_000C, DX = 64'h1234_5678_9ABC_DEF0;
  localparam logic [63:0] DY = 64'h0F0F_F0F0_0F0F_F0F0, DZ = 64'hFFFF_0000_FFFF_0001;
  localparam logic [63:0] D0 = 64'h0;
  function automatic vec_t mk(int sv, int su, logic [63:0] sd, int sr, int sl, int ru, int rr,
                              int ev, logic [63:0] ed, int er, int el, int eo);
    vec_t v;
    v.sv = sv[0]; v.suid = su[7:0]; v.sd = sd; v.sr = sr[1:0]; v.sl = sl[0];
    v.ruid = ru[7:0]; v.rr = rr[0];
    v.ev = ev[0]; v.ed = ed; v.er = er[1:0]; v.el = el[0]; v.eo = eo[2:0];
    return v;
  endfunction
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic drv(input int sv, input int su, input logic [63:0] sd, input int sr, input int sl,
                     input int ru, input int rr);
    st.valid = sv[0];
    st.id = {24'h0, su[7:0]};
    st.data = sd;
    st.resp = sr[1:0];
    st.last = sl[0];
    release_uid = {24'h0, ru[7:0]};
    rl.ready = rr[0];
  endtask
  task automatic step(input int sv, input int su, input logic [63:0] sd, input int sr, input int sl,
                      input int ru, input int rr);
    @(negedge clk);
    drv(sv, su, sd, sr, sl, ru, rr);
    #2;
  endtask
  initial begin
    tv[0]  = mk(1, 'h12, DA, 0, 0, 'h12, 0, 0, D0, 0, 0, 0);
    tv[1]  = mk(1, 'h12, DB, 1, 0, 'h12, 0, 1, DA, 0, 0, 1);
    tv[2]  = mk(1, 'h12, DC, 2, 1, 'h12, 0, 1, DA, 0, 0, 2);
    tv[3]  = mk(0, 0, D0, 0, 0, 'h12, 1, 1, DA, 0, 0, 3);
    tv[4]  = mk(0, 0, D0, 0, 0, 'h12, 1, 1, DB, 1, 0, 2);
    tv[5]  = mk(0, 0, D0, 0, 0, 'h12, 1, 1, DC, 2, 1, 1);
    tv[6]  = mk(0, 0, D0, 0, 0, 'h12, 0, 0, D0, 0, 0, 0);
    tv[7]  = mk(1, 'h05, DX, 3, 0, 'h05, 0, 0, D0, 0, 0, 0);
    tv[8]  = mk(1, 'h07, DY, 1, 1, 'h07, 0, 0, D0, 0, 0, 1);
    tv[9]  = mk(1, 'h05, DZ, 2, 1, 'h07, 1, 1, DY, 1, 1, 2);
    tv[10] = mk(0, 0, D0, 0, 0, 'h05, 1, 1, DX, 3, 0, 2);
    tv[11] = mk(0, 0, D0, 0, 0, 'h05, 1, 1, DZ, 2, 1, 1);
    tv[12] = mk(0, 0, D0, 0, 0, 'h07, 0, 0, D0, 0, 0, 0);
    drv(0, 0, D0, 0, 0, 0, 0);
    #12;
    chk("rst_ready", st.ready, 1);
    chk("rst_valid", rl.valid, 0);
    chk("rst_occ", occ, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 13; i++) begin
      step(tv[i].sv, tv[i].suid, tv[i].sd, tv[i].sr, tv[i].sl, tv[i].ruid, tv[i].rr);
      chk($sformatf("v%0d_ready", i), st.ready, 1);
      chk($sformatf("v%0d_valid", i), rl.valid, tv[i].ev);
      chk($sformatf("v%0d_data", i), rl.data, tv[i].ed);
      chk($sformatf("v%0d_resp", i), rl.resp, tv[i].er);
      chk($sformatf("v%0d_last", i), rl.last, tv[i].el);
      chk($sformatf("v%0d_occ", i), occ, tv[i].eo);
      chk($sformatf("v%0d_empty", i), empty, tv[i].eo == 0);
      chk($sformatf("v%0d_id", i), rl.id, {24'h0, tv[i].ruid});
    end
    for (int i = 0; i < 4; i++) step(1, 'h30 + i, 64'hD0 + 64'(i), 0, 1, 'h30, 0);
    step(0, 0, D0, 0, 0, 'h31, 1);
    chk("full_flag", full, 1);
    chk("full_ready", st.ready, 0);
    chk("full_occ", occ, 4);
    chk("full_rel_data", rl.data, 64'hD1);
    step(0, 0, D0, 0, 0, 'h31, 0);
    chk("reuse_ready", st.ready, 1);
    chk("reuse_full", full, 0);
    chk("reuse_gone", rl.valid, 0);
    step(1, 'h34, 64'hDEAD, 1, 1, 'h34, 0);
    chk("reuse_nobypass", rl.valid, 0);
    step(0, 0, D0, 0, 0, 'h34, 1);
    chk("reuse_valid", rl.valid, 1);
    chk("reuse_data", rl.data, 64'hDEAD);
    chk("reuse_resp", rl.resp, 1);
    chk("reuse_full2", full, 1);
    step(0, 0, D0, 0, 0, 'h30, 1);
    chk("drain30", rl.data, 64'hD0);
    step(0, 0, D0, 0, 0, 'h32, 1);
    chk("drain32", rl.data, 64'hD2);
    step(0, 0, D0, 0, 0, 'h33, 1);
    chk("drain33", rl.data, 64'hD3);
    step(0, 0, D0, 0, 0, 'h30, 0);
    chk("drain_empty", empty, 1);
    step(1, 'h21, 64'hE1, 1, 1, 'h21, 1);
    chk("same_empty_valid", rl.valid, 0);
    step(1, 'h21, 64'hE2, 2, 1, 'h21, 1);
    chk("same_next_valid", rl.valid, 1);
    chk("same_old_data", rl.data, 64'hE1);
    chk("same_old_resp", rl.resp, 1);
    chk("same_occ1", occ, 1);
    step(0, 0, D0, 0, 0, 'h21, 0);
    chk("same_new_valid", rl.valid, 1);
    chk("same_new_data", rl.data, 64'hE2);
    chk("same_new_resp", rl.resp, 2);
    chk("same_cnt_occ", occ, 1);
    step(0, 0, D0, 0, 0, 'h21, 1);
    chk("same_pop", rl.data, 64'hE2);
    step(0, 0, D0, 0, 0, 'h21, 0);
    chk("same_drained", rl.valid, 0);
    chk("same_empty", empty, 1);
    step(1, 'h40, 64'hF0, 0, 1, 'h40, 0);
    step(1, 'h41, 64'hF1, 0, 1, 'h40, 0);
    chk("pre_rst_f0", rl.data, 64'hF0);
    step(0, 0, D0, 0, 0, 'h41, 0);
    chk("pre_rst_occ", occ, 2);
    chk("pre_rst_f1", rl.data, 64'hF1);
    @(negedge clk);
    rst = 1'b1;
    #2;
    chk("mid_rst_occ", occ, 0);
    chk("mid_rst_empty", empty, 1);
    chk("mid_rst_v41", rl.valid, 0);
    chk("mid_rst_ready", st.ready, 1);
    release_uid = 32'h40;
    #1;
    chk("mid_rst_v40", rl.valid, 0);
    @(negedge clk);
    rst = 1'b0;
    step(1, 'h40, 64'hF9, 3, 1, 'h40, 0);
    chk("post_rst_nobypass", rl.valid, 0);
    step(0, 0, D0, 0, 0, 'h40, 1);
    chk("post_rst_valid", rl.valid, 1);
    chk("post_rst_data", rl.data, 64'hF9);
    chk("post_rst_resp", rl.resp, 3);
    chk("post_rst_occ", occ, 1);
    step(0, 0, D0, 0, 0, 'h40, 0);
    chk("post_rst_drained", rl.valid, 0);
    chk("post_rst_empty", empty, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
